// File: rtl/calendar_pkg.sv
// ============================================================================
// Module      : calendar_pkg
// Description : Shared field widths, UI state codes and leap-year rule for the
//               calendar stages.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package calendar_pkg;

  localparam int unsigned DAY_W   = 5;
  localparam int unsigned MONTH_W = 4;
  localparam int unsigned YEAR_W  = 15;

  localparam logic [4:0] STATE_DAY   = 5'd2;
  localparam logic [4:0] STATE_MONTH = 5'd3;
  localparam logic [4:0] STATE_YEAR  = 5'd4;

  localparam logic [YEAR_W-1:0] YEAR_MAX = 15'd9999;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_ADVANCE,
    ACT_DAY_DEC,
    ACT_MONTH_DEC,
    ACT_DAY_INC,
    ACT_MONTH_INC
  } act_e;

  function automatic logic is_leap(input logic [YEAR_W-1:0] year);
    return (year[1:0] == 2'b00) &&
           (((year % 15'd100) != 15'd0) || ((year % 15'd400) == 15'd0));
  endfunction

endpackage

`default_nettype wire

// File: rtl/days_in_month.sv
// ============================================================================
// Module      : days_in_month
// Description : Combinational month length lookup, leap-year aware.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module days_in_month
  import calendar_pkg::*;
(
  input  logic [3:0]  month,
  input  logic [14:0] year,
  output logic [4:0]  dim
);

  always_comb begin
    dim = 5'd31;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = is_leap(year) ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/day_month.sv
// ============================================================================
// Module      : day_month
// Description : Day-of-month / month stage with rollover, year-advance strobe
//               and manual plus/minus adjustment.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module day_month #(
  parameter logic [4:0] STATE_DAY   = calendar_pkg::STATE_DAY,
  parameter logic [4:0] STATE_MONTH = calendar_pkg::STATE_MONTH
) (
  input  logic        i_clk_0_001s,
  input  logic        reset,
  input  logic [4:0]  state,
  input  logic        is_modify,
  input  logic        i_plus,
  input  logic        i_minus,
  input  logic        i_enable,
  input  logic [14:0] i_year,
  output logic        o_enable,
  output logic [4:0]  o_day,
  output logic [3:0]  o_month
);

  import calendar_pkg::*;

  logic       en_q, en_fall_q;
  logic       plus_q, plus_fall_q;
  logic       minus_q, minus_fall_q;
  logic [4:0] day_q, day_d;
  logic [3:0] month_q, month_d;
  logic       enable_q, enable_d;
  logic [4:0] dim_cur, dim_adj;
  logic [3:0] month_adj;
  act_e       act;

  days_in_month u_dim_cur (.month(month_q),   .year(i_year), .dim(dim_cur));
  // Length of the month a manual month step would land on, for the day clamp.
  days_in_month u_dim_adj (.month(month_adj), .year(i_year), .dim(dim_adj));

  always_comb begin
    act = ACT_HOLD;
    if (en_fall_q)
      act = ACT_ADVANCE;
    else if (minus_fall_q && is_modify && state == STATE_DAY)
      act = ACT_DAY_DEC;
    else if (minus_fall_q && is_modify && state == STATE_MONTH)
      act = ACT_MONTH_DEC;
    else if (plus_fall_q && is_modify && state == STATE_DAY)
      act = ACT_DAY_INC;
    else if (plus_fall_q && is_modify && state == STATE_MONTH)
      act = ACT_MONTH_INC;
  end

  always_comb begin
    if (act == ACT_MONTH_DEC)
      month_adj = (month_q == 4'd1) ? 4'd12 : month_q - 4'd1;
    else
      month_adj = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
  end

  always_comb begin
    day_d    = day_q;
    month_d  = month_q;
    enable_d = 1'b0;
    case (act)
      ACT_ADVANCE: begin
        if (day_q < dim_cur) begin
          day_d = day_q + 5'd1;
        end else begin
          day_d = 5'd1;
          if (month_q < 4'd12) begin
            month_d = month_q + 4'd1;
          end else begin
            month_d  = 4'd1;
            enable_d = 1'b1;
          end
        end
      end
      ACT_DAY_DEC: day_d = (day_q == 5'd1) ? dim_cur : day_q - 5'd1;
      ACT_DAY_INC: day_d = (day_q == dim_cur) ? 5'd1 : day_q + 5'd1;
      ACT_MONTH_DEC, ACT_MONTH_INC: begin
        month_d = month_adj;
        day_d   = (day_q > dim_adj) ? dim_adj : day_q;
      end
      default: begin
        // Year changes from the upstream stage can shrink February under us.
        if (day_q > dim_cur)
          day_d = dim_cur;
      end
    endcase
  end

  always_ff @(posedge i_clk_0_001s or negedge reset) begin
    if (!reset) begin
      en_q         <= 1'b0;
      en_fall_q    <= 1'b0;
      plus_q       <= 1'b0;
      plus_fall_q  <= 1'b0;
      minus_q      <= 1'b0;
      minus_fall_q <= 1'b0;
      day_q        <= 5'd1;
      month_q      <= 4'd1;
      enable_q     <= 1'b0;
    end else begin
      en_q         <= i_enable;
      en_fall_q    <= en_q & ~i_enable;
      plus_q       <= i_plus;
      plus_fall_q  <= plus_q & ~i_plus;
      minus_q      <= i_minus;
      minus_fall_q <= minus_q & ~i_minus;
      day_q        <= day_d;
      month_q      <= month_d;
      enable_q     <= enable_d;
    end
  end

  assign o_day    = day_q;
  assign o_month  = month_q;
  assign o_enable = enable_q;

endmodule

`default_nettype wire
